// File: rtl/svreal_reg_arbiter.sv
// svreal_reg_arbiter: round-robin arbiter granting N requesters load/saturating-add access to one fixed-point register
module svreal_reg_arbiter #(
    parameter int  N_REQ    = 3,
    parameter int  WIDTH    = 16,
    parameter int  EXPONENT = -8,
    parameter real INIT_VAL = 1.23,
    localparam int IDW      = $clog2(N_REQ > 1 ? N_REQ : 2)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_op,
    input  logic [N_REQ*WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic signed [WIDTH-1:0]   q,
    output logic                      upd,
    output logic [IDW-1:0]            upd_id,
    output logic                      sat
);
    // $rtoi truncates toward zero, so offsetting by +/-0.5 first rounds half away from zero
    localparam real SCALED = INIT_VAL * (2.0 ** (-EXPONENT));
    localparam real RND    = SCALED >= 0.0 ? SCALED + 0.5 : SCALED - 0.5;
    localparam real MAXR   = (2.0 ** (WIDTH - 1)) - 1.0;
    localparam real MINR   = -(2.0 ** (WIDTH - 1));
    localparam real CLIP   = RND > MAXR ? MAXR : (RND < MINR ? MINR : RND);
    localparam integer INIT_I = $rtoi(CLIP);
    localparam logic signed [WIDTH-1:0] INIT_FIXED = INIT_I[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          winner;
    logic [IDW-1:0]          cand;
    logic                    found;
    logic                    grant;
    logic                    op;
    logic signed [WIDTH-1:0] data;
    logic signed [WIDTH:0]   sum;
    logic                    ovf;
    logic signed [WIDTH-1:0] clipped;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant     = rst_n & ce & found;
    assign req_ready = grant ? (N_REQ'(1) << winner) : '0;
    assign op        = req_op[winner];
    assign data      = req_data[winner*WIDTH +: WIDTH];
    assign sum       = {q[WIDTH-1], q} + {data[WIDTH-1], data};
    assign ovf       = sum[WIDTH] ^ sum[WIDTH-1];
    assign clipped   = ovf ? (sum[WIDTH] ? MIN_V : MAX_V) : sum[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q      <= INIT_FIXED;
            ptr    <= '0;
            upd    <= 1'b0;
            sat    <= 1'b0;
            upd_id <= '0;
        end else begin
            upd <= grant;
            sat <= grant & op & ovf;
            if (grant) begin
                q      <= op ? clipped : data;
                ptr    <= winner == IDW'(N_REQ - 1) ? '0 : winner + 1'b1;
                upd_id <= winner;
            end
        end
    end
endmodule

// File: tb/tb_svreal_reg_arbiter.sv
// tb_svreal_reg_arbiter: directed vectors with hand-computed expectations
module tb_svreal_reg_arbiter;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic [2:0]         req_valid;
    logic [2:0]         req_op;
    logic signed [15:0] d [3];
    logic [47:0]        req_data;
    logic [2:0]         req_ready;
    logic signed [15:0] q;
    logic               upd;
    logic [1:0]         upd_id;
    logic               sat;
    int                 n_checks = 0;
    int                 n_fail   = 0;

    assign req_data = {d[2], d[1], d[0]};

    svreal_reg_arbiter #(.N_REQ(3), .WIDTH(16), .EXPONENT(-8), .INIT_VAL(1.23)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_ready(req_ready), .q(q), .upd(upd), .upd_id(upd_id), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; req_valid = 3'b111; req_op = 3'b000;
        d[0] = 16'sd100; d[1] = 16'sd200; d[2] = 16'sd300;
        #1;
        check("rst_ready", req_ready, 3'b000);
        cyc();
        check("rst_q", q, 315);
        check("rst_upd", upd, 0);
        check("rst_sat", sat, 0);
        check("rst_id", upd_id, 0);

        rst_n = 1'b1; req_valid = 3'b001; d[0] = 16'sd599;
        #1;
        check("ld_ready", req_ready, 3'b001);
        cyc();
        check("ld_q", q, 599);
        check("ld_upd", upd, 1);
        check("ld_id", upd_id, 0);
        req_valid = 3'b000;
        cyc();
        check("idle_upd", upd, 0);
        check("idle_q", q, 599);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; req_valid = 3'b111; d[0] = 16'sd100;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", req_ready, 3'b001 << (i % 3));
            cyc();
            check("rr_q", q, 100 * ((i % 3) + 1));
            check("rr_id", upd_id, i % 3);
            check("rr_upd", upd, 1);
        end

        req_valid = 3'b001; req_op = 3'b000; d[0] = 16'sd32512;
        #1;
        check("sat_ready", req_ready, 3'b001);
        cyc();
        check("ld_pos_q", q, 32512);
        check("ld_pos_sat", sat, 0);
        req_op = 3'b001; d[0] = 16'sd256;
        cyc();
        check("add_pos_q", q, 32767);
        check("add_pos_sat", sat, 1);
        req_op = 3'b000; d[0] = -16'sd32512;
        cyc();
        check("ld_neg_q", q, -32512);
        req_op = 3'b001; d[0] = -16'sd512;
        cyc();
        check("add_neg_q", q, -32768);
        check("add_neg_sat", sat, 1);
        req_op = 3'b000; d[0] = 16'sd0;
        cyc();
        req_op = 3'b001; d[0] = 16'sd256;
        cyc();
        check("add_ok_q", q, 256);
        check("add_ok_sat", sat, 0);
        check("add_ok_upd", upd, 1);

        req_op = 3'b000; req_valid = 3'b010; d[1] = 16'sd882; ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ce_ready", req_ready, 3'b000);
            cyc();
            check("ce_q", q, 256);
            check("ce_upd", upd, 0);
        end
        ce = 1'b1;
        #1;
        check("ce_resume_ready", req_ready, 3'b010);
        cyc();
        check("ce_resume_q", q, 882);
        check("ce_resume_id", upd_id, 1);

        req_valid = 3'b111; d[0] = 16'sd100; d[1] = 16'sd200; d[2] = 16'sd300;
        #1;
        check("ptr2_ready", req_ready, 3'b100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 3'b000);
        cyc();
        check("mid_rst_q", q, 315);
        check("mid_rst_upd", upd, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 3'b001);
        cyc();
        check("post_rst_q", q, 100);
        check("post_rst_id", upd_id, 0);

        ce = 1'b0; rst_n = 1'b0;
        cyc();
        check("rst_ce0_q", q, 315);
        check("rst_ce0_id", upd_id, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
